// File: rtl/shift_unit_iter_if.sv
// shift_unit_iter_if: request/result bundle between the operand muxes, the shifter and write-back.
interface shift_unit_iter_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
);
    logic               start;
    logic [2:0]         mode;
    logic               amt_src;
    logic [SHAMT_W-1:0] shamt_imm;
    logic [WIDTH-1:0]   amt_reg;
    logic [WIDTH-1:0]   data_in;
    logic [WIDTH-1:0]   result;
    logic               busy;
    logic               done;

    modport master (
        output start, mode, amt_src, shamt_imm, amt_reg, data_in,
        input  result, busy, done
    );

    modport slave (
        input  start, mode, amt_src, shamt_imm, amt_reg, data_in,
        output result, busy, done
    );
endinterface

// File: rtl/shift_unit_iter.sv
// shift_unit_iter: multi-cycle shifter/rotator stepping one bit per clock, amount from shamt_imm or an amt_reg slice.
// Define SHIFT_FAST_EN to load the fully shifted value in one cycle instead of iterating.
module shift_unit_iter #(
    parameter int WIDTH        = 32,
    parameter int SHAMT_W      = $clog2(WIDTH),
    parameter bit AMT_FROM_MSB = 1'b0
) (
    input logic              clk,
    input logic              reset,
    shift_unit_iter_if.slave bus
);
    localparam logic [2:0] M_NOP = 3'd0;
    localparam logic [2:0] M_SLL = 3'd1;
    localparam logic [2:0] M_SRL = 3'd2;
    localparam logic [2:0] M_SRA = 3'd3;
    localparam logic [2:0] M_ROL = 3'd4;
    localparam logic [2:0] M_ROR = 3'd5;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_nx;
    logic [WIDTH-1:0]   result_q, result_nx;
    logic [SHAMT_W-1:0] cnt, cnt_nx, amt;
    logic [2:0]         mode_q, mode_nx;
    logic               done_q, done_nx, mode_ok;

    // Rotates come from the doubled word so wrap-around needs no extra muxing.
    function automatic logic [WIDTH-1:0] shift_by(
        input logic [WIDTH-1:0]   x,
        input logic [2:0]         m,
        input logic [SHAMT_W-1:0] a
    );
        logic [2*WIDTH-1:0] rol, ror;
        logic [WIDTH-1:0]   sra;
        rol = {x, x} << a;
        ror = {x, x} >> a;
        sra = $signed(x) >>> a;
        return m == M_SLL ? x << a :
               m == M_SRL ? x >> a :
               m == M_SRA ? sra :
               m == M_ROL ? rol[2*WIDTH-1:WIDTH] :
               m == M_ROR ? ror[WIDTH-1:0] : x;
    endfunction

    assign amt = !bus.amt_src ? bus.shamt_imm :
                 AMT_FROM_MSB ? bus.amt_reg[WIDTH-1 -: SHAMT_W] : bus.amt_reg[SHAMT_W-1:0];
    assign mode_ok = bus.mode inside {M_SLL, M_SRL, M_SRA, M_ROL, M_ROR};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            result_q <= '0;
            cnt      <= '0;
            mode_q   <= M_NOP;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nx;
            result_q <= result_nx;
            cnt      <= cnt_nx;
            mode_q   <= mode_nx;
            done_q   <= done_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        result_nx = result_q;
        cnt_nx    = cnt;
        mode_nx   = mode_q;
        done_nx   = 1'b0;
        if (state == IDLE) begin
            if (bus.start) begin
                state_nx = RUN;
                mode_nx  = mode_ok ? bus.mode : M_NOP;
`ifdef SHIFT_FAST_EN
                result_nx = shift_by(bus.data_in, mode_nx, amt);
                cnt_nx    = '0;
`else
                result_nx = bus.data_in;
                cnt_nx    = mode_ok ? amt : '0;
`endif
            end
        end else if (cnt != '0) begin
            result_nx = shift_by(result_q, mode_q, SHAMT_W'(1));
            cnt_nx    = cnt - SHAMT_W'(1);
        end else begin
            state_nx = IDLE;
            done_nx  = 1'b1;
        end
    end

    assign bus.result = result_q;
    assign bus.done   = done_q;
`ifdef SHIFT_FAST_EN
    assign bus.busy   = 1'b0;
`else
    assign bus.busy   = state == RUN;
`endif
endmodule

// File: tb/tb_shift_unit_iter.sv
// tb_shift_unit_iter: directed vectors on two instances (LSB and MSB amount slice) against a timing/value model.
module tb_shift_unit_iter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  mode = 3'd0;
    logic        amt_src = 1'b0;
    logic [4:0]  shamt_imm = 5'd0;
    logic [31:0] amt_reg = 32'd0;
    logic [31:0] data_in = 32'd0;
    int          tests = 0;
    int          fails = 0;

`ifdef SHIFT_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    shift_unit_iter_if #(.WIDTH(32)) b0 ();
    shift_unit_iter_if #(.WIDTH(32)) b1 ();

    assign b0.start = start;     assign b1.start = start;
    assign b0.mode = mode;       assign b1.mode = mode;
    assign b0.amt_src = amt_src; assign b1.amt_src = amt_src;
    assign b0.shamt_imm = shamt_imm; assign b1.shamt_imm = shamt_imm;
    assign b0.amt_reg = amt_reg; assign b1.amt_reg = amt_reg;
    assign b0.data_in = data_in; assign b1.data_in = data_in;

    shift_unit_iter #(.WIDTH(32), .AMT_FROM_MSB(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(b0));
    shift_unit_iter #(.WIDTH(32), .AMT_FROM_MSB(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(b1));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] x, input logic [2:0] m, input int k);
        logic [31:0] y;
        y = x;
        for (int j = 0; j < k; j++)
            case (m)
                3'd1: y = y * 2;
                3'd2: y = y / 2;
                3'd3: y = y / 2 + (y & 32'h80000000);
                3'd4: y = {y[30:0], y[31]};
                3'd5: y = {y[0], y[31:1]};
                default: y = y;
            endcase
        return y;
    endfunction

    // Model: each instance remembers its last accepted operation and the edge it started on.
    int          cyc = 0;
    bit          m_valid [2] = '{1'b0, 1'b0};
    int          m_s [2];
    int          m_a [2];
    logic [2:0]  m_m [2];
    logic [31:0] m_d [2];

    function automatic int amount_of(input int i);
        if (!amt_src) return int'(shamt_imm);
        return i == 0 ? int'(amt_reg[4:0]) : int'(amt_reg[31:27]);
    endfunction

    always @(posedge clk or posedge reset) begin
        int t;
        if (reset) begin
            m_valid = '{1'b0, 1'b0};
        end else begin
            for (int i = 0; i < 2; i++) begin
                t = FAST ? 0 : m_a[i];
                if (start && (!m_valid[i] || cyc - m_s[i] >= t + 2)) begin
                    m_valid[i] = 1'b1;
                    m_s[i] = cyc;
                    m_d[i] = data_in;
                    m_m[i] = mode;
                    m_a[i] = (mode >= 3'd1 && mode <= 3'd5) ? amount_of(i) : 0;
                end
            end
            cyc++;
        end
    end

    task automatic check_one(input int i, input logic [31:0] res, input logic busy, input logic done);
        int n, t, k;
        logic [31:0] er;
        logic eb, ed;
        n = cyc - 1 - m_s[i];
        t = FAST ? 0 : m_a[i];
        k = FAST ? m_a[i] : (n < m_a[i] ? n : m_a[i]);
        er = m_valid[i] ? ref_shift(m_d[i], m_m[i], k) : 32'd0;
        eb = m_valid[i] && !FAST && n <= t;
        ed = m_valid[i] && n == t + 1;
        chk($sformatf("cyc%0d result[%0d]", cyc, i), res, er);
        chk($sformatf("cyc%0d busy[%0d]", cyc, i), {31'd0, busy}, {31'd0, eb});
        chk($sformatf("cyc%0d done[%0d]", cyc, i), {31'd0, done}, {31'd0, ed});
    endtask

    always @(negedge clk) begin
        check_one(0, b0.result, b0.busy, b0.done);
        check_one(1, b1.result, b1.busy, b1.done);
    end

    // Entered and left #1 after a rising edge; l0/l1 are iterative latencies (edges from start to done).
    task automatic run(input string name, input logic [2:0] m, input logic src, input logic [4:0] imm,
                       input logic [31:0] ar, input logic [31:0] d,
                       input int l0, input logic [31:0] r0, input int l1, input logic [31:0] r1);
        int g0, g1;
        logic [31:0] q0, q1;
        start = 1'b1; mode = m; amt_src = src; shamt_imm = imm; amt_reg = ar; data_in = d;
        @(posedge clk); #1 start = 1'b0;
        g0 = -1; g1 = -1; q0 = 'x; q1 = 'x;
        for (int k = 1; k <= 80 && (g0 < 0 || g1 < 0); k++) begin
            @(posedge clk); #1;
            if (g0 < 0 && b0.done) begin g0 = k; q0 = b0.result; end
            if (g1 < 0 && b1.done) begin g1 = k; q1 = b1.result; end
        end
        chk({name, "_lat0"}, g0, FAST ? 1 : l0);
        chk({name, "_res0"}, q0, r0);
        chk({name, "_lat1"}, g1, FAST ? 1 : l1);
        chk({name, "_res1"}, q1, r1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset_result", b0.result, 32'd0);
        chk("reset_busy", {31'd0, b0.busy}, 32'd0);
        chk("reset_done", {31'd0, b0.done}, 32'd0);
        chk("model_rol", ref_shift(32'h80000001, 3'd4, 4), 32'h00000018);
        chk("model_sra", ref_shift(32'h80000000, 3'd3, 31), 32'hFFFFFFFF);
        chk("model_ror", ref_shift(32'h00000001, 3'd5, 1), 32'h80000000);

        run("t1_sll4",  3'd1, 1'b0, 5'd4,  32'h0,        32'h00000001, 5,  32'h00000010, 5, 32'h00000010);
        run("t2_sra31", 3'd3, 1'b1, 5'd0,  32'h0000001F, 32'h80000000, 32, 32'hFFFFFFFF, 1, 32'h80000000);
        run("t2_srl31", 3'd2, 1'b1, 5'd0,  32'h0000001F, 32'h80000000, 32, 32'h00000001, 1, 32'h80000000);
        run("t3_ror1",  3'd5, 1'b0, 5'd1,  32'h0,        32'h00000001, 2,  32'h80000000, 2, 32'h80000000);
        run("t3_rol4",  3'd4, 1'b0, 5'd4,  32'h0,        32'h80000001, 5,  32'h00000018, 5, 32'h00000018);
        run("t4_srl",   3'd2, 1'b1, 5'd0,  32'h80000001, 32'hFFFF0000, 2,  32'h7FFF8000, 17, 32'h0000FFFF);
        run("t5_amt0",  3'd1, 1'b0, 5'd0,  32'h0,        32'h00001234, 1,  32'h00001234, 1, 32'h00001234);
        run("t5_m111",  3'd7, 1'b0, 5'd9,  32'h0,        32'h00001234, 1,  32'h00001234, 1, 32'h00001234);
        run("t5_nop",   3'd0, 1'b0, 5'd5,  32'h0,        32'h0000CAFE, 1,  32'h0000CAFE, 1, 32'h0000CAFE);
        run("x_ror31",  3'd5, 1'b1, 5'd0,  32'h0000001F, 32'h00000001, 32, 32'h00000002, 1, 32'h00000001);
        run("x_sra_pos",3'd3, 1'b0, 5'd30, 32'h0,        32'h40000000, 31, 32'h00000001, 31, 32'h00000001);

        start = 1'b1; mode = 3'd1; amt_src = 1'b0; shamt_imm = 5'd8; data_in = 32'h000000FF;
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 start = 1'b1; data_in = 32'h0000ABCD;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #3 reset = 1'b1;
        #1;
        chk("t6_rst_result", b0.result, 32'd0);
        chk("t6_rst_busy", {31'd0, b0.busy}, 32'd0);
        chk("t6_rst_done", {31'd0, b0.done}, 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (b0.done || b1.done) seen = 1'b1;
        end
        chk("t6_no_done", {31'd0, seen}, 32'd0);
        run("t6_after", 3'd1, 1'b0, 5'd3, 32'h0, 32'h00000001, 4, 32'h00000008, 4, 32'h00000008);

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
